// File: rtl/real_mul_seq_ctrl.sv
// real_mul_seq_ctrl
//   Sequential IEEE-754 multiplier controller. It handles one operation at a time.
//   Operands are accepted over a valid/ready handshake.
//   The mantissas are multiplied with an iterative shift-add, one multiplier bit per cycle.
//   The product is then normalised and rounded to nearest-even.
//   Out-of-range exponents are flushed to zero or saturated to infinity.
//   NaN, infinity, zero and denormal operands skip the multiply and go straight to DONE.
//
// Ports
//   clk        rising-edge clock
//   rst_n      synchronous active-low reset
//   in_valid   operands a/b valid
//   in_ready   controller can accept (state == IDLE)
//   a, b       operands, captured on accept
//   out_valid  result/flags valid, held until out_ready
//   out_ready  consumer accepts result
//   result     packed product
//   flags      {invalid, overflow, underflow, inexact}
//   busy       state != IDLE
module real_mul_seq_ctrl #(
    parameter int IS_DOUBLE  = 0,
    parameter int EXP_WIDTH  = IS_DOUBLE ? 11 : 8,
    parameter int MANT_WIDTH = IS_DOUBLE ? 52 : 23
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]       a,
    input  logic [EXP_WIDTH+MANT_WIDTH:0]       b,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [EXP_WIDTH+MANT_WIDTH:0]       result,
    output logic [3:0]                          flags,
    output logic                                busy
);
    localparam int BIAS = IS_DOUBLE ? 1023 : 127;
    localparam int W    = 1 + EXP_WIDTH + MANT_WIDTH;
    localparam int P    = 2 * MANT_WIDTH + 2;          // full product width
    localparam int CW   = $clog2(MANT_WIDTH + 1);      // iteration counter width
    localparam int XW   = EXP_WIDTH + 2;               // signed working exponent width

    localparam logic [XW-1:0] BIAS_X  = XW'(BIAS);
    localparam logic [XW-1:0] EXP_MAX = {2'b00, {EXP_WIDTH{1'b1}}};
    localparam logic [W-1:0]  QNAN    = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(MANT_WIDTH-1){1'b0}}};

    typedef enum logic [2:0] {IDLE, MUL, NORM, RND, DONE} state_t;

    state_t                  state_reg;
    logic                    out_valid_reg;
    logic [W-1:0]            result_reg;
    logic [3:0]              flags_reg;
    logic                    sign_reg;
    logic [XW-1:0]           exp_reg;
    logic [MANT_WIDTH:0]     mcand_reg;
    logic [MANT_WIDTH:0]     mplier_reg;
    logic [P-1:0]            acc_reg;
    logic [CW-1:0]           cnt_reg;
    logic [MANT_WIDTH-1:0]   frac_reg;
    logic                    g_reg, r_reg, s_reg;

    // Operand field decode
    logic [EXP_WIDTH-1:0]    a_exp, b_exp;
    logic [MANT_WIDTH-1:0]   a_frac, b_frac;
    logic a_exp_zero, a_exp_ones, a_nan, a_snan, a_inf;
    logic b_exp_zero, b_exp_ones, b_nan, b_snan, b_inf;
    logic sign_next, special_next;
    logic [XW-1:0]           exp_sum_next;

    assign a_exp  = a[W-2 -: EXP_WIDTH];
    assign b_exp  = b[W-2 -: EXP_WIDTH];
    assign a_frac = a[MANT_WIDTH-1:0];
    assign b_frac = b[MANT_WIDTH-1:0];

    assign a_exp_zero = (a_exp == '0);
    assign b_exp_zero = (b_exp == '0);
    assign a_exp_ones = &a_exp;
    assign b_exp_ones = &b_exp;
    assign a_nan  = a_exp_ones && (|a_frac);
    assign b_nan  = b_exp_ones && (|b_frac);
    assign a_snan = a_nan && !a_frac[MANT_WIDTH-1];
    assign b_snan = b_nan && !b_frac[MANT_WIDTH-1];
    assign a_inf  = a_exp_ones && !(|a_frac);
    assign b_inf  = b_exp_ones && !(|b_frac);

    assign sign_next    = a[W-1] ^ b[W-1];
    assign special_next = a_exp_zero | a_exp_ones | b_exp_zero | b_exp_ones;
    // Two's-complement wrap of the subtraction gives the signed biased sum.
    assign exp_sum_next = {2'b00, a_exp} + {2'b00, b_exp} - BIAS_X;

    // Special-case result, in priority order. Denormals count as zero.
    logic [W-1:0] sp_result_next;
    logic [3:0]   sp_flags_next;
    always_comb begin
        sp_result_next = '0;
        sp_flags_next  = '0;
        if (a_nan || b_nan) begin
            sp_result_next   = QNAN;
            sp_flags_next[3] = a_snan | b_snan;
        end else if ((a_inf && b_exp_zero) || (b_inf && a_exp_zero)) begin
            sp_result_next   = QNAN;
            sp_flags_next[3] = 1'b1;
        end else if (a_inf || b_inf) begin
            sp_result_next = {sign_next, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
        end else begin
            sp_result_next = {sign_next, {(W-1){1'b0}}};
        end
    end

    // Rounding and range check, evaluated from the normalised registers
    logic                  rnd_inc;
    logic [MANT_WIDTH:0]   rnd_sum;
    logic [XW-1:0]         exp_fin;
    logic                  inexact_next, ovf_next, unf_next;
    logic [W-1:0]          rnd_result_next;
    logic [3:0]            rnd_flags_next;
    always_comb begin
        rnd_inc      = g_reg & (r_reg | s_reg | frac_reg[0]);
        rnd_sum      = {1'b0, frac_reg} + {{MANT_WIDTH{1'b0}}, rnd_inc};
        // A mantissa carry-out leaves the low bits at zero, so only the exponent moves.
        exp_fin      = exp_reg + {{(XW-1){1'b0}}, rnd_sum[MANT_WIDTH]};
        inexact_next = g_reg | r_reg | s_reg;
        ovf_next     = ($signed(exp_fin) >= $signed(EXP_MAX));
        unf_next     = exp_fin[XW-1] || (exp_fin == '0);
        rnd_result_next = {sign_reg, exp_fin[EXP_WIDTH-1:0], rnd_sum[MANT_WIDTH-1:0]};
        rnd_flags_next  = {3'b000, inexact_next};
        if (ovf_next) begin
            rnd_result_next = {sign_reg, {EXP_WIDTH{1'b1}}, {MANT_WIDTH{1'b0}}};
            rnd_flags_next  = 4'b0101;
        end else if (unf_next) begin
            rnd_result_next = {sign_reg, {(W-1){1'b0}}};
            rnd_flags_next  = 4'b0011;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            out_valid_reg <= 1'b0;
            result_reg    <= '0;
            flags_reg     <= '0;
            sign_reg      <= 1'b0;
            exp_reg       <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            frac_reg      <= '0;
            g_reg         <= 1'b0;
            r_reg         <= 1'b0;
            s_reg         <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg   <= sign_next;
                        exp_reg    <= exp_sum_next;
                        mcand_reg  <= {1'b1, a_frac};
                        mplier_reg <= {1'b1, b_frac};
                        acc_reg    <= '0;
                        cnt_reg    <= '0;
                        if (special_next) begin
                            result_reg <= sp_result_next;
                            flags_reg  <= sp_flags_next;
                            state_reg  <= DONE;
                        end else begin
                            state_reg  <= MUL;
                        end
                    end
                end
                MUL: begin
                    if (mplier_reg[cnt_reg])
                        acc_reg <= acc_reg + (P'(mcand_reg) << cnt_reg);
                    if (cnt_reg == CW'(MANT_WIDTH))
                        state_reg <= NORM;
                    else
                        cnt_reg <= cnt_reg + CW'(1);
                end
                NORM: begin
                    // Product lies in [1,4); the top bit selects a one-place right shift.
                    if (acc_reg[P-1]) begin
                        frac_reg <= acc_reg[P-2 -: MANT_WIDTH];
                        g_reg    <= acc_reg[MANT_WIDTH];
                        r_reg    <= acc_reg[MANT_WIDTH-1];
                        s_reg    <= |acc_reg[MANT_WIDTH-2:0];
                    end else begin
                        frac_reg <= acc_reg[P-3 -: MANT_WIDTH];
                        g_reg    <= acc_reg[MANT_WIDTH-1];
                        r_reg    <= acc_reg[MANT_WIDTH-2];
                        s_reg    <= |acc_reg[MANT_WIDTH-3:0];
                    end
                    exp_reg   <= exp_reg + {{(XW-1){1'b0}}, acc_reg[P-1]};
                    state_reg <= RND;
                end
                RND: begin
                    result_reg <= rnd_result_next;
                    flags_reg  <= rnd_flags_next;
                    state_reg  <= DONE;
                end
                DONE: begin
                    // First DONE cycle raises out_valid; then it waits for the consumer.
                    if (!out_valid_reg) begin
                        out_valid_reg <= 1'b1;
                    end else if (out_ready) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= IDLE;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign in_ready  = (state_reg == IDLE);
    assign busy      = (state_reg != IDLE);
    assign out_valid = out_valid_reg;
    assign result    = result_reg;
    assign flags     = flags_reg;

endmodule
